// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared constants, state encoding and checksum type for the boot loader
package program_loader_pkg;
    localparam int DEF_MEM_SIZE  = 4096;
    localparam int DEF_WORD_SIZE = 20;
    localparam int DEF_ADDR_SIZE = 16;

    function automatic int bpw(input int word_size);
        return (word_size + 7) / 8;
    endfunction

    localparam int BPW = bpw(DEF_WORD_SIZE);

    typedef logic [7:0] csum_t;
    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t CNT_HI = 3'd1;
    localparam state_t CNT_LO = 3'd2;
    localparam state_t BYTE   = 3'd3;
    localparam state_t WRITE  = 3'd4;
    localparam state_t CSUM   = 3'd5;
    localparam state_t DONE   = 3'd6;
    localparam state_t ERROR  = 3'd7;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: host byte stream plus program RAM write port
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
);
    logic [7:0]           rx_data_i;
    logic                 rx_valid_i;
    logic                 rx_ready_o;
    logic                 wr_en_o;
    logic [ADDR_SIZE-1:0] wr_addr_o;
    logic [WORD_SIZE-1:0] wr_data_o;

    modport slave  (input rx_data_i, rx_valid_i, output rx_ready_o, wr_en_o, wr_addr_o, wr_data_o);
    modport master (output rx_data_i, rx_valid_i, input rx_ready_o, wr_en_o, wr_addr_o, wr_data_o);
endinterface

// File: rtl/program_loader_word_assembler.sv
// word_assembler: big-endian byte shift register; word_full flags that the next shift completes a word
module word_assembler
    import program_loader_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int NB        = BPW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 shift,
    input  logic [7:0]           data,
    output logic [WORD_SIZE-1:0] word,
    output logic                 word_full
);
    localparam int IW = NB > 1 ? $clog2(NB) : 1;

    logic [IW-1:0] idx;

    assign word_full = idx == IW'(NB - 1);

    // bits shifted above WORD_SIZE fall off, discarding the excess of the first byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (shift) begin
            word <= WORD_SIZE'({word, data});
            idx  <= word_full ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a checksummed image into program RAM, holding the core in reset until it verifies
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEM_SIZE  = DEF_MEM_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    program_loader_if.slave  bus,
    output logic             cpu_reset_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);
    localparam logic [16:0] MAX_N = 17'(MEM_SIZE);

    state_t               state, nxt;
    logic [15:0]          remaining;
    logic [15:0]          n;
    logic [ADDR_SIZE-1:0] addr;
    csum_t                sum;
    logic                 accept, launch, word_full;
    logic [WORD_SIZE-1:0] word;

    assign accept = bus.rx_valid_i && bus.rx_ready_o;
    assign launch = start_i && (state == IDLE || state == DONE || state == ERROR);
    // remaining holds COUNT_HI in its low byte until COUNT_LO arrives
    assign n = {remaining[7:0], bus.rx_data_i};
    assign bus.wr_addr_o = addr;
    assign bus.wr_data_o = word;

    word_assembler #(.WORD_SIZE(WORD_SIZE), .NB(bpw(WORD_SIZE))) u_asm (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (launch),
        .shift     (accept && state == BYTE),
        .data      (bus.rx_data_i),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERROR: nxt = launch ? CNT_HI : state;
            CNT_HI:            nxt = accept ? CNT_LO : state;
            CNT_LO:            if (accept) nxt = (n == 16'd0) ? CSUM : ({1'b0, n} > MAX_N) ? ERROR : BYTE;
            BYTE:              nxt = (accept && word_full) ? WRITE : state;
            WRITE:             nxt = (remaining == 16'd1) ? CSUM : BYTE;
            CSUM:              if (accept) nxt = (csum_t'(sum + bus.rx_data_i) == 8'd0) ? DONE : ERROR;
            default:           nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            remaining      <= '0;
            addr           <= '0;
            sum            <= '0;
            bus.rx_ready_o <= 1'b0;
            bus.wr_en_o    <= 1'b0;
            cpu_reset_o    <= 1'b1;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            state          <= nxt;
            bus.rx_ready_o <= nxt == CNT_HI || nxt == CNT_LO || nxt == BYTE || nxt == CSUM;
            bus.wr_en_o    <= nxt == WRITE;
            cpu_reset_o    <= nxt != DONE;
            busy_o         <= !(nxt == IDLE || nxt == DONE || nxt == ERROR);
            done_o         <= nxt == DONE;
            error_o        <= nxt == ERROR;
            if (launch) begin
                sum  <= '0;
                addr <= '0;
            end else begin
                if (accept) sum <= sum + bus.rx_data_i;
                if (state == WRITE) addr <= addr + 1'b1;
            end
            if (accept && state == CNT_HI) remaining <= {8'd0, bus.rx_data_i};
            else if (accept && state == CNT_LO) remaining <= n;
            else if (state == WRITE) remaining <= remaining - 16'd1;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed scenarios for the boot-time program loader
module tb_program_loader;
    import program_loader_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic start_i = 1'b0;
    logic cpu_reset_o, busy_o, done_o, error_o;

    program_loader_if #(.WORD_SIZE(20), .ADDR_SIZE(16)) bus();

    program_loader #(.MEM_SIZE(4096), .WORD_SIZE(20), .ADDR_SIZE(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_i),
        .bus         (bus.slave),
        .cpu_reset_o (cpu_reset_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] wa[$];
    logic [19:0] wd[$];
    int wc[$];

    always @(posedge clk) cyc++;

    // RAM-side view of the write port, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.wr_en_o === 1'b1) begin
            wa.push_back(bus.wr_addr_o);
            wd.push_back(bus.wr_data_o);
            wc.push_back(cyc);
        end
    end

    task automatic make_image(input logic [15:0] n, input logic [23:0] w[$], input logic [7:0] delta,
                              output logic [7:0] b[$]);
        logic [7:0] s;
        b = {};
        b.push_back(n[15:8]);
        b.push_back(n[7:0]);
        foreach (w[i]) begin
            b.push_back(w[i][23:16]);
            b.push_back(w[i][15:8]);
            b.push_back(w[i][7:0]);
        end
        s = 8'd0;
        foreach (b[i]) s = s + b[i];
        b.push_back(8'(8'd0 - s + delta));
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wa = {};
        wd = {};
        wc = {};
    endtask

    task automatic send(input logic [7:0] b[$], input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < b.size() && guard < b.size() * 8 + 100) begin
            @(negedge clk);
            bus.rx_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rx_data_i = b[i];
            if (gaps) start_i = 1'($urandom_range(0, 1));
            if (bus.rx_valid_i && bus.rx_ready_o) i++;
            guard++;
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        start_i = 1'b0;
        checks++;
        if (i != b.size()) begin
            errors++;
            $display("FAIL send_timeout: accepted %0d of %0d bytes", i, b.size());
        end
    endtask

    task automatic check_two_word_image(input string tag, input bit expect_ok, input bit timing);
        @(negedge clk);
        checks++;
        if (wa.size() !== 2) begin errors++; $display("FAIL %s_wcount: got %0d want 2", tag, wa.size()); end
        if (wa.size() >= 2) begin
            checks += 4;
            if (wa[0] !== 16'd0)    begin errors++; $display("FAIL %s_addr0: got %h want 0", tag, wa[0]); end
            if (wd[0] !== 20'h12345) begin errors++; $display("FAIL %s_data0: got %h want 12345", tag, wd[0]); end
            if (wa[1] !== 16'd1)    begin errors++; $display("FAIL %s_addr1: got %h want 1", tag, wa[1]); end
            if (wd[1] !== 20'hABCDE) begin errors++; $display("FAIL %s_data1: got %h want abcde", tag, wd[1]); end
            if (timing) begin
                checks++;
                if (wc[1] - wc[0] !== 4) begin errors++; $display("FAIL %s_spacing: got %0d want 4", tag, wc[1] - wc[0]); end
            end
        end
        checks += 6;
        if (done_o !== expect_ok)       begin errors++; $display("FAIL %s_done: got %b want %b", tag, done_o, expect_ok); end
        if (error_o !== !expect_ok)     begin errors++; $display("FAIL %s_error: got %b want %b", tag, error_o, !expect_ok); end
        if (cpu_reset_o !== !expect_ok) begin errors++; $display("FAIL %s_cpu_reset: got %b want %b", tag, cpu_reset_o, !expect_ok); end
        if (busy_o !== 1'b0)            begin errors++; $display("FAIL %s_busy: got %b want 0", tag, busy_o); end
        if (bus.wr_addr_o !== 16'd2)    begin errors++; $display("FAIL %s_wr_addr: got %h want 2", tag, bus.wr_addr_o); end
        if (bus.rx_ready_o !== 1'b0)    begin errors++; $display("FAIL %s_ready: got %b want 0", tag, bus.rx_ready_o); end
    endtask

    task automatic two_word_image(input logic [7:0] delta, output logic [7:0] b[$]);
        logic [23:0] w[$];
        w.push_back(24'h012345);
        w.push_back(24'h0ABCDE);
        make_image(16'd2, w, delta, b);
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks += 8;
        if (bus.rx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.rx_ready_o); end
        if (bus.wr_en_o !== 1'b0)    begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en_o); end
        if (bus.wr_addr_o !== 16'd0) begin errors++; $display("FAIL reset_wr_addr: got %h want 0", bus.wr_addr_o); end
        if (bus.wr_data_o !== 20'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data_o); end
        if (cpu_reset_o !== 1'b1)    begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset_o); end
        if (busy_o !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        if (done_o !== 1'b0)         begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        if (error_o !== 1'b0)        begin errors++; $display("FAIL reset_error: got %b want 0", error_o); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rx_ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", bus.rx_ready_o); end
    endtask

    task automatic test_load();
        logic [7:0] b[$];
        two_word_image(8'd0, b);
        start_pulse();
        checks += 3;
        if (busy_o !== 1'b1)         begin errors++; $display("FAIL start_busy: got %b want 1", busy_o); end
        if (cpu_reset_o !== 1'b1)    begin errors++; $display("FAIL start_cpu_reset: got %b want 1", cpu_reset_o); end
        if (bus.rx_ready_o !== 1'b1) begin errors++; $display("FAIL start_ready: got %b want 1", bus.rx_ready_o); end
        send(b, 1'b0);
        check_two_word_image("load", 1'b1, 1'b1);
    endtask

    task automatic test_bad_csum();
        logic [7:0] b[$];
        two_word_image(8'd1, b);
        start_pulse();
        send(b, 1'b0);
        check_two_word_image("badsum", 1'b0, 1'b1);
    endtask

    task automatic test_oversize();
        logic [7:0] b[$];
        b.push_back(8'h10);
        b.push_back(8'h01);
        start_pulse();
        send(b, 1'b0);
        repeat (3) @(negedge clk);
        checks += 5;
        if (wa.size() !== 0)         begin errors++; $display("FAIL over_writes: got %0d want 0", wa.size()); end
        if (error_o !== 1'b1)        begin errors++; $display("FAIL over_error: got %b want 1", error_o); end
        if (busy_o !== 1'b0)         begin errors++; $display("FAIL over_busy: got %b want 0", busy_o); end
        if (cpu_reset_o !== 1'b1)    begin errors++; $display("FAIL over_cpu_reset: got %b want 1", cpu_reset_o); end
        if (bus.rx_ready_o !== 1'b0) begin errors++; $display("FAIL over_ready: got %b want 0", bus.rx_ready_o); end
    endtask

    task automatic test_zero();
        logic [7:0] b[$];
        logic [23:0] w[$];
        make_image(16'd0, w, 8'd0, b);
        start_pulse();
        send(b, 1'b0);
        @(negedge clk);
        checks += 4;
        if (wa.size() !== 0)         begin errors++; $display("FAIL zero_writes: got %0d want 0", wa.size()); end
        if (done_o !== 1'b1)         begin errors++; $display("FAIL zero_done: got %b want 1", done_o); end
        if (error_o !== 1'b0)        begin errors++; $display("FAIL zero_error: got %b want 0", error_o); end
        if (bus.wr_addr_o !== 16'd0) begin errors++; $display("FAIL zero_wr_addr: got %h want 0", bus.wr_addr_o); end
    endtask

    task automatic test_excess_bits();
        logic [7:0] b[$];
        logic [23:0] w[$];
        w.push_back(24'hF12345);
        make_image(16'd1, w, 8'd0, b);
        start_pulse();
        send(b, 1'b0);
        @(negedge clk);
        checks += 3;
        if (wa.size() !== 1) begin errors++; $display("FAIL excess_wcount: got %0d want 1", wa.size()); end
        else if (wd[0] !== 20'h12345) begin errors++; $display("FAIL excess_data: got %h want 12345", wd[0]); end
        if (done_o !== 1'b1) begin errors++; $display("FAIL excess_done: got %b want 1", done_o); end
        if (bus.wr_addr_o !== 16'd1) begin errors++; $display("FAIL excess_wr_addr: got %h want 1", bus.wr_addr_o); end
    endtask

    task automatic test_max();
        logic [7:0] b[$];
        logic [23:0] w[$];
        int bad = 0;
        for (int i = 0; i < 4096; i++) w.push_back(24'(i * 37 + 5));
        make_image(16'd4096, w, 8'd0, b);
        start_pulse();
        send(b, 1'b0);
        @(negedge clk);
        checks += 4;
        if (wa.size() !== 4096) begin errors++; $display("FAIL max_wcount: got %0d want 4096", wa.size()); end
        for (int i = 0; i < wa.size() && i < 4096; i++)
            if (wa[i] !== 16'(i) || wd[i] !== 20'(i * 37 + 5)) bad++;
        if (bad !== 0)                 begin errors++; $display("FAIL max_contents: %0d bad words want 0", bad); end
        if (done_o !== 1'b1)           begin errors++; $display("FAIL max_done: got %b want 1", done_o); end
        if (bus.wr_addr_o !== 16'd4096) begin errors++; $display("FAIL max_wr_addr: got %h want 1000", bus.wr_addr_o); end
    endtask

    task automatic test_gaps();
        logic [7:0] b[$];
        two_word_image(8'd0, b);
        start_pulse();
        send(b, 1'b1);
        check_two_word_image("gaps", 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        logic [7:0] p[$];
        two_word_image(8'd0, b);
        for (int i = 0; i < 4; i++) p.push_back(b[i]);
        start_pulse();
        send(p, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks += 7;
        if (bus.rx_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", bus.rx_ready_o); end
        if (bus.wr_data_o !== 20'd0) begin errors++; $display("FAIL mid_wr_data: got %h want 0", bus.wr_data_o); end
        if (bus.wr_addr_o !== 16'd0) begin errors++; $display("FAIL mid_wr_addr: got %h want 0", bus.wr_addr_o); end
        if (busy_o !== 1'b0)         begin errors++; $display("FAIL mid_busy: got %b want 0", busy_o); end
        if (cpu_reset_o !== 1'b1)    begin errors++; $display("FAIL mid_cpu_reset: got %b want 1", cpu_reset_o); end
        if (done_o !== 1'b0)         begin errors++; $display("FAIL mid_done: got %b want 0", done_o); end
        if (error_o !== 1'b0)        begin errors++; $display("FAIL mid_error: got %b want 0", error_o); end
        @(negedge clk);
        reset_n = 1'b1;
        start_pulse();
        send(b, 1'b0);
        check_two_word_image("after_reset", 1'b1, 1'b1);
    endtask

    initial begin
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i = 8'd0;
        test_reset();
        test_load();
        test_bad_csum();
        test_oversize();
        test_zero();
        test_excess_bits();
        test_gaps();
        test_max();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
